// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector onto a small combinational cell, captures its truth table after a
// programmable settle time and compares it against an expected table.
module truth_table_sweeper #(
  parameter int unsigned          N_IN          = 2,
  parameter int unsigned          SETTLE_CYCLES = 1,
  parameter logic [(2**N_IN)-1:0] EXPECTED      = 4'b0010
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  output logic [N_IN-1:0]         dut_in,
  input  logic                    dut_s,
  output logic                    busy,
  output logic                    done,
  output logic [(2**N_IN)-1:0]    table_out,
  output logic                    match,
  output logic [N_IN:0]           mismatch_count
);

  localparam int unsigned NVec = 2**N_IN;
  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  state_e           r_state;
  logic [N_IN-1:0]  r_idx;
  logic [CntW-1:0]  r_cnt;
  logic [NVec-1:0]  r_table;
  logic [N_IN:0]    r_mm;
  logic             r_match;

  logic             w_miss;
  logic [NVec-1:0]  w_table_upd;

  // Table as it will look after the current SAMPLE cycle; match is judged on this value.
  always_comb begin
    w_miss              = dut_s ^ EXPECTED[r_idx];
    w_table_upd         = r_table;
    w_table_upd[r_idx]  = dut_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_table <= '0;
      r_mm    <= '0;
      r_match <= 1'b0;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_state <= StSettle;
            r_idx   <= '0;
            r_cnt   <= CntLoad;
            r_table <= '0;
            r_mm    <= '0;
            r_match <= 1'b0;
          end
        end
        StSettle: begin
          if (abort) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_table <= '0;
            r_mm    <= '0;
            r_match <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state <= StSample;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StSample: begin
          if (abort) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_table <= '0;
            r_mm    <= '0;
            r_match <= 1'b0;
          end else begin
            r_table <= w_table_upd;
            r_mm    <= r_mm + {{N_IN{1'b0}}, w_miss};
            if (r_idx == {N_IN{1'b1}}) begin
              // Last vector: stop here, idx never wraps.
              r_state <= StDone;
              r_match <= (w_table_upd == EXPECTED);
            end else begin
              r_state <= StSettle;
              r_idx   <= r_idx + 1'b1;
              r_cnt   <= CntLoad;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign dut_in         = r_idx;
  assign busy           = (r_state == StSettle) || (r_state == StSample);
  assign done           = (r_state == StDone);
  assign table_out      = r_table;
  assign match          = r_match;
  assign mismatch_count = r_mm;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: sweep launches push expected results, monitors pop them on done rising.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, abort, start2, mode, s_ok2;
  logic [1:0] dut_in, dut_in2;
  logic       dut_s, dut_s2, w_cell2;
  logic       busy, done, match, busy2, done2, match2;
  logic [3:0] table_out, table2;
  logic [2:0] mm, mm2;

  // Cell models: mode 0 is ~a & b, mode 1 is an a | b stub.
  assign dut_s   = mode ? (dut_in[1] | dut_in[0]) : (~dut_in[1] & dut_in[0]);
  // Second cell outputs the wrong value except on the SAMPLE cycle.
  assign w_cell2 = ~dut_in2[1] & dut_in2[0];
  assign dut_s2  = s_ok2 ? w_cell2 : ~w_cell2;

  truth_table_sweeper #(.N_IN(2), .SETTLE_CYCLES(1), .EXPECTED(4'b0010)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .dut_in(dut_in), .dut_s(dut_s),
    .busy(busy), .done(done), .table_out(table_out), .match(match), .mismatch_count(mm)
  );

  truth_table_sweeper #(.N_IN(2), .SETTLE_CYCLES(3), .EXPECTED(4'b0010)) u_dut3 (
    .clk(clk), .reset(reset), .start(start2), .abort(1'b0), .dut_in(dut_in2), .dut_s(dut_s2),
    .busy(busy2), .done(done2), .table_out(table2), .match(match2), .mismatch_count(mm2)
  );

  typedef struct packed {
    logic [3:0] tbl;
    logic       m;
    logic [2:0] cnt;
  } res_t;

  res_t q1[$];
  res_t q2[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon1();
    logic prev = 1'b0;
    res_t e;
    forever begin
      @(negedge clk);
      if (done && !prev) begin
        chk("sb1 result expected", 32'(q1.size() != 0), 1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          chk("sb1 table_out", table_out, e.tbl);
          chk("sb1 match", match, e.m);
          chk("sb1 mismatch_count", mm, e.cnt);
        end
      end
      prev = done;
    end
  endtask

  task automatic mon2();
    logic prev = 1'b0;
    res_t e;
    forever begin
      @(negedge clk);
      if (done2 && !prev) begin
        chk("sb2 result expected", 32'(q2.size() != 0), 1);
        if (q2.size() != 0) begin
          e = q2.pop_front();
          chk("sb2 table_out", table2, e.tbl);
          chk("sb2 match", match2, e.m);
          chk("sb2 mismatch_count", mm2, e.cnt);
        end
      end
      prev = done2;
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, " dut_in"}, dut_in, 0);
    chk({name, " busy"}, busy, 0);
    chk({name, " done"}, done, 0);
    chk({name, " table_out"}, table_out, 0);
    chk({name, " match"}, match, 0);
    chk({name, " mismatch_count"}, mm, 0);
  endtask

  // Full sweep on the SETTLE_CYCLES=1 instance; optional stray start after edge restart_at.
  task automatic sweep1(input logic m, input logic [3:0] t, input logic mt, input logic [2:0] c,
                        input int restart_at);
    res_t e;
    mode = m;
    @(negedge clk);
    start = 1'b1;
    e.tbl = t; e.m = mt; e.cnt = c;
    q1.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("sweep dut_in", dut_in, k / 2);
      chk("sweep busy", busy, 1);
      chk("sweep match low while busy", match, 0);
      start = (k == restart_at);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("done at edge 8", done, 1);
    chk("dut_in holds last vector", dut_in, 3);
    chk("busy low in done", busy, 0);
  endtask

  initial begin
    res_t e;
    reset = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0; mode = 1'b0; s_ok2 = 1'b1;
    fork
      mon1();
      mon2();
    join_none

    // Reset and idle hold
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    chk("reset busy2", busy2, 0);
    chk("reset done2", done2, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("idle hold");

    // ~a & b and a | b sweeps
    sweep1(1'b0, 4'b0010, 1'b1, 3'd0, -1);
    sweep1(1'b1, 4'b1110, 1'b0, 3'd2, -1);
    repeat (5) @(posedge clk);
    #1;
    chk("done stable", done, 1);
    chk("table stable", table_out, 4'b1110);
    chk("mismatch stable", mm, 2);

    // Abort in DONE has no effect
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort in done: done", done, 1);
    chk("abort in done: table", table_out, 4'b1110);
    chk("abort in done: dut_in", dut_in, 3);

    // Stray start during a sweep is ignored
    sweep1(1'b0, 4'b0010, 1'b1, 3'd0, 2);

    // Start+abort together in DONE: start wins; later abort cancels a partial sweep
    mode = 1'b1;
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start beats abort in done", busy, 1);
    chk("done falls on start", done, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("partial table before abort", table_out, 4'b0110);
    chk("partial mismatch before abort", mm, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk_zero("after abort");
    repeat (10) @(posedge clk);
    #1;
    chk("stays idle after abort", busy | done, 0);

    // Reset mid-sweep, then a clean sweep
    mode = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("busy before mid reset", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_zero("mid-sweep reset");
    sweep1(1'b0, 4'b0010, 1'b1, 3'd0, -1);

    // SETTLE_CYCLES = 3 with a misbehaving cell outside SAMPLE
    @(negedge clk);
    start2 = 1'b1;
    s_ok2 = 1'b0;
    e.tbl = 4'b0010; e.m = 1'b1; e.cnt = 3'd0;
    q2.push_back(e);
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int c = 0; c < 16; c++) begin
      s_ok2 = ((c % 4) == 3);
      chk("settle3 dut_in", dut_in2, c / 4);
      chk("settle3 busy", busy2, 1);
      @(posedge clk); #1;
    end
    s_ok2 = 1'b1;
    chk("settle3 done at edge 16", done2, 1);
    chk("settle3 dut_in holds last", dut_in2, 3);

    repeat (3) @(posedge clk);
    #1;
    chk("sb1 drained", q1.size(), 0);
    chk("sb2 drained", q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
